axis_adc_capture_ctrl: RTL and testbench
========================================

Name: axis_adc_capture_ctrl

Overview:
Triggered acquisition sequencer for the dual-channel ADC capture path. It sits downstream of the DDR de-interleaver and takes both 14-bit ADC channel words every aclk. Once armed and triggered, and after a programmable delay, it forwards a programmed number of decimated sample pairs onto an AXI4-Stream master, then returns to idle. It reports state, sample count, completion and overrun to the control registers.

Parameters:
ADC_DATA_WIDTH, 14, width of each ADC channel word; legal range 2..16
CNTR_WIDTH, 32, width of the delay, length and sample counters
DECIM_WIDTH, 16, width of the decimation divider

Ports:
aclk  in  1  system clock
areset  in  1  synchronous, active-high reset
adc_dat_0  in  ADC_DATA_WIDTH  channel 0 word, two's complement, new value every aclk
adc_dat_1  in  ADC_DATA_WIDTH  channel 1 word, two's complement
cfg_arm  in  1  single-cycle pulse; arms the capture
cfg_abort  in  1  single-cycle pulse; cancels the capture
cfg_sw_trig  in  1  single-cycle software trigger
ext_trig  in  1  external trigger, already synchronised to aclk; rising edge is the event
cfg_delay  in  CNTR_WIDTH  aclk cycles between the trigger and the start of capture
cfg_length  in  CNTR_WIDTH  number of sample pairs to capture
cfg_decim  in  DECIM_WIDTH  capture one pair every cfg_decim+1 cycles
m_axis_tdata  out  32  {sext16(ch1), sext16(ch0)}
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tlast  out  1  marks the final pair of a capture
sts_state  out  3  0 IDLE, 1 ARMED, 2 DELAY, 3 CAPTURE, 4 FLUSH
sts_count  out  CNTR_WIDTH  pairs taken in the current capture, dropped pairs included
sts_done  out  1  sticky; set at completion, cleared by cfg_arm
sts_overrun  out  1  sticky; set on any dropped pair, cleared by cfg_arm

Behaviour:
- Reset: all of the following are 0 — state IDLE, m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_count, sts_done, sts_overrun, and the ext_trig edge register.
- cfg_* values are sampled when cfg_arm is accepted in IDLE and held internally for the whole capture. Later changes to cfg_* have no effect until the next arm.
- IDLE:
  - cfg_arm with cfg_length!=0 -> ARMED. Also clears sts_done, sts_overrun and sts_count.
  - cfg_arm with cfg_length==0 is ignored.
- ARMED:
  - A trigger event is cfg_sw_trig=1, or ext_trig=1 while its registered previous value is 0.
  - Trigger with delay==0 -> CAPTURE.
  - Trigger with delay>0 -> DELAY, with the delay counter loaded to delay-1.
  - Triggers in any other state are ignored.
- DELAY: counter decrements each cycle; the cycle it reads 0 -> CAPTURE. The first capture cycle is therefore exactly delay+1 cycles after the trigger cycle.
- CAPTURE:
  - The decimation counter is cleared on entry.
  - A strobe fires when the counter is 0; the counter wraps at cfg_decim. The first CAPTURE cycle is always a strobe.
  - On a strobe, sts_count increments.
  - The pair is loaded into the output register if the register is free (tvalid=0, or tvalid&tready in that cycle). It appears with tvalid=1 on the next cycle, a latency of 1.
  - If the register is not free, the pair is dropped and sts_overrun is set.
  - The pair with sts_count reaching cfg_length is the last pair:
    - If loaded: tlast=1 with it, state -> IDLE, sts_done=1.
    - If not loaded: it goes into a one-entry pending slot and state -> FLUSH. The last pair is never dropped.
- FLUSH: the pending pair is loaded with tlast=1 as soon as the output register is free; then -> IDLE and sts_done=1.
- AXIS rules:
  - tdata and tlast are stable while tvalid&!tready.
  - tvalid falls only after a handshake.
  - tlast=0 on every beat except the last pair.
- cfg_abort:
  - Takes priority over every other event in the same cycle.
  - Any state -> IDLE; the pending slot is discarded; sts_done is not set.
  - A beat already valid on the output stays valid until accepted and keeps its tlast value.
- cfg_arm while not IDLE is ignored. cfg_arm together with cfg_abort: the abort wins and the arm is ignored.
- Sign extension: bit ADC_DATA_WIDTH-1 of each channel is replicated into the upper bits of its 16-bit half.
- areset mid-capture returns every output to its reset value on the next edge, including a beat that is still valid.

Test Plan:
- length=4, delay=0, decim=0, tready=1, sw_trig one cycle after arm -> 4 consecutive beats; first beat 1 cycle after CAPTURE entry; tlast on the 4th beat; sts_done=1, state 0.
- ext_trig held high before arm, then low, then high -> no trigger until the second rising edge; delay=5 -> CAPTURE entered 6 cycles after that edge.
- decim=3, length=3, adc_dat_0 ramping +1 per cycle, adc_dat_1=14'h2000 -> beats carry ch0 = v, v+4, v+8; ch1 half = 16'hE000.
- tready=0 throughout a length=3, decim=0 capture -> beat 1 held stable, pair 2 dropped, pair 3 goes to FLUSH; sts_overrun=1; raising tready delivers beat 1, then pair 3 with tlast.
- cfg_abort in DELAY and in CAPTURE with a beat pending -> state 0, sts_done=0, the held beat still completes; a subsequent arm clears the sts flags.
- arm with length=0 -> stays IDLE; areset asserted in CAPTURE -> tvalid=0 and all status fields 0 next cycle.

Source files
------------

// File: rtl/axis_adc_capture_ctrl_if.sv
// AXI4-Stream beat channel carrying one decimated ADC sample pair per transfer.
interface axis_adc_capture_ctrl_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_adc_capture_ctrl.sv
// Triggered dual-channel ADC acquisition sequencer: arm, trigger, delay, then stream
// a fixed number of decimated sample pairs onto AXI4-Stream.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for cfg_arm with a non-zero length
// S_ARMED   | config latched, waiting for a software or external trigger
// S_DELAY   | counting down the post-trigger delay
// S_CAPTURE | taking one pair every decim+1 cycles
// S_FLUSH   | last pair parked in the pending slot until the output frees up
module axis_adc_capture_ctrl #(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int CNTR_WIDTH     = 32,
    parameter int DECIM_WIDTH    = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_0,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_1,
    input  logic                      cfg_arm,
    input  logic                      cfg_abort,
    input  logic                      cfg_sw_trig,
    input  logic                      ext_trig,
    input  logic [CNTR_WIDTH-1:0]     cfg_delay,
    input  logic [CNTR_WIDTH-1:0]     cfg_length,
    input  logic [DECIM_WIDTH-1:0]    cfg_decim,
    axis_adc_capture_ctrl_if.master   m_axis,
    output logic [2:0]                sts_state,
    output logic [CNTR_WIDTH-1:0]     sts_count,
    output logic                      sts_done,
    output logic                      sts_overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_FLUSH   = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CNTR_WIDTH-1:0]  delay_q, length_q, dly_cnt, count;
    logic [DECIM_WIDTH-1:0] decim_q, dec_cnt;
    logic [31:0]            tdata_q, pend_q, pair, load_data;
    logic                   tvalid_q, tlast_q, done_q, overrun_q, ext_trig_q;
    logic                   trig_evt, out_free, strobe, is_last;
    logic                   arm_acc, dly_load, dec_clr, cnt_inc, load, load_last;
    logic                   pend_wr, set_done, set_ovr;

    function automatic logic [15:0] sext16(input logic [ADC_DATA_WIDTH-1:0] d);
        return 16'($signed(d));
    endfunction

    assign trig_evt = cfg_sw_trig | (ext_trig & ~ext_trig_q);
    assign out_free = ~tvalid_q | m_axis.tready;
    assign strobe   = (dec_cnt == '0);
    assign pair     = {sext16(adc_dat_1), sext16(adc_dat_0)};
    assign is_last  = ((count + CNTR_WIDTH'(1)) == length_q);

    always_comb begin
        state_nxt = state;
        arm_acc   = 1'b0;
        dly_load  = 1'b0;
        dec_clr   = 1'b0;
        cnt_inc   = 1'b0;
        load      = 1'b0;
        load_data = pair;
        load_last = 1'b0;
        pend_wr   = 1'b0;
        set_done  = 1'b0;
        set_ovr   = 1'b0;
        if (cfg_abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_arm && cfg_length != '0) begin
                        arm_acc   = 1'b1;
                        state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_evt) begin
                        dec_clr = 1'b1;
                        if (delay_q == '0) begin
                            state_nxt = S_CAPTURE;
                        end else begin
                            dly_load  = 1'b1;
                            state_nxt = S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    dec_clr = 1'b1;
                    if (dly_cnt == '0) state_nxt = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (strobe) begin
                        cnt_inc = 1'b1;
                        if (out_free) begin
                            load      = 1'b1;
                            load_last = is_last;
                            if (is_last) begin
                                set_done  = 1'b1;
                                state_nxt = S_IDLE;
                            end
                        end else if (is_last) begin
                            // the final pair is never dropped; park it instead
                            pend_wr   = 1'b1;
                            state_nxt = S_FLUSH;
                        end else begin
                            set_ovr = 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = pend_q;
                        load_last = 1'b1;
                        set_done  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= S_IDLE;
            delay_q    <= '0;
            length_q   <= '0;
            decim_q    <= '0;
            dly_cnt    <= '0;
            dec_cnt    <= '0;
            count      <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            pend_q     <= '0;
            ext_trig_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            ext_trig_q <= ext_trig;
            if (arm_acc) begin
                delay_q   <= cfg_delay;
                length_q  <= cfg_length;
                decim_q   <= cfg_decim;
                count     <= '0;
                done_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (dly_load)               dly_cnt <= delay_q - CNTR_WIDTH'(1);
            else if (state == S_DELAY)  dly_cnt <= dly_cnt - CNTR_WIDTH'(1);
            if (dec_clr)                dec_cnt <= '0;
            else if (state == S_CAPTURE)
                dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DECIM_WIDTH'(1);
            if (cnt_inc)  count     <= count + CNTR_WIDTH'(1);
            if (set_done) done_q    <= 1'b1;
            if (set_ovr)  overrun_q <= 1'b1;
            if (pend_wr)  pend_q    <= pair;
            if (load) begin
                tdata_q  <= load_data;
                tvalid_q <= 1'b1;
                tlast_q  <= load_last;
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign sts_state     = state;
    assign sts_count     = count;
    assign sts_done      = done_q;
    assign sts_overrun   = overrun_q;

endmodule

// File: tb/tb_axis_adc_capture_ctrl.sv
// Randomized bench for axis_adc_capture_ctrl against a timeline-based reference model,
// plus directed scenarios with hand-computed expectations.
module tb_axis_adc_capture_ctrl;
    localparam int W = 14;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [W-1:0]  adc_dat_0 = '0, adc_dat_1 = '0;
    logic          cfg_arm = 0, cfg_abort = 0, cfg_sw_trig = 0, ext_trig = 0;
    logic [31:0]   cfg_delay = 0, cfg_length = 0;
    logic [15:0]   cfg_decim = 0;
    logic [2:0]    sts_state;
    logic [31:0]   sts_count;
    logic          sts_done, sts_overrun;

    axis_adc_capture_ctrl_if axis_if();

    axis_adc_capture_ctrl #(.ADC_DATA_WIDTH(W), .CNTR_WIDTH(32), .DECIM_WIDTH(16)) dut (
        .aclk(aclk), .areset(areset),
        .adc_dat_0(adc_dat_0), .adc_dat_1(adc_dat_1),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_sw_trig(cfg_sw_trig), .ext_trig(ext_trig),
        .cfg_delay(cfg_delay), .cfg_length(cfg_length), .cfg_decim(cfg_decim),
        .m_axis(axis_if),
        .sts_state(sts_state), .sts_count(sts_count), .sts_done(sts_done), .sts_overrun(sts_overrun)
    );

    always #5 aclk = ~aclk;

    int     n_cmp = 0, n_bad = 0;
    longint cyc = 0;
    bit     started = 0, ramp = 0, rnd_ready = 0;
    logic [32:0] beats[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC sources and randomized sink back-pressure
    always @(posedge aclk) begin
        #1;
        if (ramp) begin
            adc_dat_0 = adc_dat_0 + W'(1);
            adc_dat_1 = 14'h2000;
        end else begin
            adc_dat_0 = W'($urandom);
            adc_dat_1 = W'($urandom);
        end
        if (rnd_ready) axis_if.tready = (($urandom % 4) != 0);
    end

    // Reference model: capture timing derived from trigger cycle arithmetic
    int          m_phase = 0;
    longint      m_start = 0;
    logic [31:0] m_dly = 0, m_len = 0, m_count = 0;
    logic [15:0] m_dec = 0;
    logic        m_done = 0, m_ovr = 0, m_valid = 0, m_last = 0, ext_prev = 0;
    logic [31:0] m_data = 0, m_pend = 0;

    function automatic logic [15:0] sx(input logic [W-1:0] d);
        return {{(16-W){d[W-1]}}, d};
    endfunction

    always @(posedge aclk) begin
        logic trig, free, ld, lst, last_pair;
        logic [31:0] ldata, p;
        if (areset) begin
            m_phase = 0; m_count = 0; m_done = 0; m_ovr = 0;
            m_valid = 0; m_last = 0; m_data = 0; ext_prev = 0;
        end else begin
            trig = cfg_sw_trig || (ext_trig && !ext_prev);
            free = !m_valid || axis_if.tready;
            p    = {sx(adc_dat_1), sx(adc_dat_0)};
            ld = 0; lst = 0; ldata = p;
            if (cfg_abort) m_phase = 0;
            else case (m_phase)
                0: if (cfg_arm && cfg_length != 0) begin
                    m_dly = cfg_delay; m_len = cfg_length; m_dec = cfg_decim;
                    m_count = 0; m_done = 0; m_ovr = 0; m_phase = 1;
                end
                1: if (trig) begin
                    m_start = cyc + longint'(m_dly) + 1;
                    m_phase = (m_dly == 0) ? 3 : 2;
                end
                2: if (cyc + 1 == m_start) m_phase = 3;
                3: if (((cyc - m_start) % (longint'(m_dec) + 1)) == 0) begin
                    m_count = m_count + 1;
                    last_pair = (m_count == m_len);
                    if (free) begin
                        ld = 1; lst = last_pair;
                        if (last_pair) begin m_phase = 0; m_done = 1; end
                    end else if (last_pair) begin
                        m_pend = p; m_phase = 4;
                    end else m_ovr = 1;
                end
                4: if (free) begin
                    ld = 1; lst = 1; ldata = m_pend; m_phase = 0; m_done = 1;
                end
                default: m_phase = 0;
            endcase
            if (ld) begin m_valid = 1; m_data = ldata; m_last = lst; end
            else if (m_valid && axis_if.tready) begin m_valid = 0; m_last = 0; end
            ext_prev = ext_trig;
        end
        cyc++;
        started = 1;
    end

    always @(negedge aclk) begin
        if (started) begin
            chk("state",   64'(sts_state), 64'(m_phase));
            chk("count",   64'(sts_count), 64'(m_count));
            chk("done",    64'(sts_done), 64'(m_done));
            chk("overrun", 64'(sts_overrun), 64'(m_ovr));
            chk("tvalid",  64'(axis_if.tvalid), 64'(m_valid));
            chk("tlast",   64'(axis_if.tlast), 64'(m_last));
            chk("tdata",   64'(axis_if.tdata), 64'(m_data));
        end
        if (started && !areset && axis_if.tvalid && axis_if.tready)
            beats.push_back({axis_if.tlast, axis_if.tdata});
    end

    task automatic sync();
        @(posedge aclk); #2;
    endtask

    task automatic arm(input int len, input int dly, input int dec);
        cfg_length = len; cfg_delay = dly; cfg_decim = 16'(dec);
        cfg_arm = 1; sync(); cfg_arm = 0;
    endtask

    task automatic sw_trig();
        cfg_sw_trig = 1; sync(); cfg_sw_trig = 0;
    endtask

    task automatic abort();
        cfg_abort = 1; sync(); cfg_abort = 0;
    endtask

    task automatic wait_idle(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            sync();
            if (sts_state == 0 && !axis_if.tvalid) ok = 1;
        end
        chk("idle_reached", 64'(ok), 64'd1);
    endtask

    initial begin
        int cap_c, val_c, n;
        bit hit;
        axis_if.tready = 1'b1;
        repeat (3) sync();
        areset = 0;
        chk("rst_state", 64'(sts_state), 0);
        chk("rst_tvalid", 64'(axis_if.tvalid), 0);
        chk("rst_tdata", 64'(axis_if.tdata), 0);
        chk("rst_count", 64'(sts_count), 0);

        // basic 4-beat capture with full throughput
        beats.delete();
        arm(4, 0, 0);
        sw_trig();
        cap_c = -1; val_c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            if (sts_state == 3 && cap_c < 0) cap_c = k;
            if (axis_if.tvalid && val_c < 0) val_c = k;
        end
        sync();
        chk("t1_latency", 64'(val_c - cap_c), 1);
        chk("t1_beats", 64'(beats.size()), 4);
        if (beats.size() == 4) begin
            chk("t1_tlast3", 64'(beats[3][32]), 1);
            chk("t1_tlast0", 64'(beats[0][32]), 0);
        end
        chk("t1_done", 64'(sts_done), 1);
        chk("t1_state", 64'(sts_state), 0);

        // external trigger only on a genuine rising edge, then delay 5
        ext_trig = 1; sync(); sync();
        arm(2, 5, 0);
        repeat (3) sync();
        chk("t2_no_level_trig", 64'(sts_state), 1);
        ext_trig = 0; sync(); sync();
        chk("t2_still_armed", 64'(sts_state), 1);
        ext_trig = 1;
        n = 0; hit = 0;
        while (n < 20 && !hit) begin
            @(posedge aclk); n++;
            @(negedge aclk);
            if (sts_state == 3) hit = 1;
        end
        chk("t2_delay_latency", 64'(n), 6);
        sync(); ext_trig = 0;
        wait_idle(50);

        // decimation by 4 on a ramp, negative channel 1
        ramp = 1; adc_dat_0 = 14'd100;
        beats.delete();
        arm(3, 0, 3);
        sw_trig();
        wait_idle(60);
        chk("t3_beats", 64'(beats.size()), 3);
        if (beats.size() == 3) begin
            chk("t3_ch1", 64'(beats[1][31:16]), 64'h0000_0000_0000_E000);
            chk("t3_step1", 64'(16'(beats[1][15:0] - beats[0][15:0])), 4);
            chk("t3_step2", 64'(16'(beats[2][15:0] - beats[0][15:0])), 8);
            chk("t3_tlast", 64'(beats[2][32]), 1);
        end

        // stalled sink: drop middle pair, flush the last one
        axis_if.tready = 0;
        beats.delete();
        arm(3, 0, 0);
        sw_trig();
        repeat (6) sync();
        chk("t4_flush", 64'(sts_state), 4);
        chk("t4_overrun", 64'(sts_overrun), 1);
        chk("t4_count", 64'(sts_count), 3);
        axis_if.tready = 1;
        wait_idle(20);
        chk("t4_beats", 64'(beats.size()), 2);
        if (beats.size() == 2) begin
            chk("t4_first_tlast", 64'(beats[0][32]), 0);
            chk("t4_last_tlast", 64'(beats[1][32]), 1);
            chk("t4_step", 64'(16'(beats[1][15:0] - beats[0][15:0])), 2);
        end
        chk("t4_done", 64'(sts_done), 1);
        ramp = 0;

        // abort in DELAY
        arm(3, 10, 0);
        sw_trig();
        repeat (3) sync();
        chk("t5_in_delay", 64'(sts_state), 2);
        abort();
        chk("t5_abort_state", 64'(sts_state), 0);
        chk("t5_abort_done", 64'(sts_done), 0);
        // abort beats a simultaneous arm
        cfg_length = 2; cfg_arm = 1; cfg_abort = 1; sync(); cfg_arm = 0; cfg_abort = 0;
        chk("t5_arm_abort", 64'(sts_state), 0);

        // abort in CAPTURE with a held beat
        axis_if.tready = 0;
        arm(5, 0, 0);
        sw_trig();
        repeat (3) sync();
        abort();
        chk("t5b_state", 64'(sts_state), 0);
        chk("t5b_done", 64'(sts_done), 0);
        chk("t5b_held", 64'(axis_if.tvalid), 1);
        beats.delete();
        axis_if.tready = 1;
        sync();
        chk("t5b_drained", 64'(axis_if.tvalid), 0);
        chk("t5b_beats", 64'(beats.size()), 1);
        if (beats.size() == 1) chk("t5b_tlast", 64'(beats[0][32]), 0);
        arm(1, 0, 0);
        chk("t5b_rearm_state", 64'(sts_state), 1);
        chk("t5b_rearm_ovr", 64'(sts_overrun), 0);
        chk("t5b_rearm_cnt", 64'(sts_count), 0);
        abort();

        // zero length arm is ignored; reset mid-capture
        arm(0, 0, 0);
        chk("t6_len0", 64'(sts_state), 0);
        axis_if.tready = 0;
        arm(10, 0, 0);
        sw_trig();
        repeat (3) sync();
        areset = 1; sync();
        chk("t6_rst_tvalid", 64'(axis_if.tvalid), 0);
        chk("t6_rst_state", 64'(sts_state), 0);
        chk("t6_rst_count", 64'(sts_count), 0);
        chk("t6_rst_ovr", 64'(sts_overrun), 0);
        chk("t6_rst_tdata", 64'(axis_if.tdata), 0);
        areset = 0; axis_if.tready = 1;
        sync();

        // randomized captures; cfg is scrambled after arm to prove it is held
        rnd_ready = 1;
        for (int it = 0; it < 40; it++) begin
            arm($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 3));
            cfg_delay = $urandom; cfg_length = $urandom; cfg_decim = 16'($urandom);
            repeat ($urandom_range(0, 2)) sync();
            if ($urandom % 2) sw_trig();
            else begin ext_trig = 1; sync(); ext_trig = 0; end
            if ($urandom % 5 == 0) begin
                repeat ($urandom_range(0, 6)) sync();
                abort();
            end
            wait_idle(600);
        end
        rnd_ready = 0;
        sync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
